// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and limits for the unified-memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    ERR     = 2'd3
  } arb_state_t;
  localparam int TIMEOUT_MAX = 15;
  localparam int STARVE_MAX  = 3;
  localparam int TMR_W       = 4;
endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer: access timeout counter; expired marks the busy cycle whose increment reaches TIMEOUT_MAX
module arb_timer
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TMR_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + 1'b1;
  end
  assign expired = enable & (r_cnt == TMR_W'(TIMEOUT_MAX - 1));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one single-port memory to fetch and data requesters with anti-starvation and timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ifReq,
  input  logic [15:0] ifAddr,
  output logic        ifValid,
  output logic [15:0] ifData,
  output logic        ifStall,
  input  logic        dmReq,
  input  logic        dmWr,
  input  logic [15:0] dmAddr,
  input  logic [15:0] dmWrData,
  output logic        dmValid,
  output logic [15:0] dmData,
  output logic        dmStall,
  output logic        memEn,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWrData,
  input  logic [15:0] memRdData,
  input  logic        memDone,
  output logic        err
);
  arb_state_t r_state, w_next;
  logic [1:0] r_starve;
  logic w_idle, w_busy, w_grant_if, w_grant_dm, w_expired;
  assign w_idle     = r_state == IDLE;
  assign w_busy     = (r_state == BUSY_IF) | (r_state == BUSY_DM);
  assign w_grant_dm = w_idle & dmReq & ~(ifReq & (r_starve == 2'(STARVE_MAX)));
  assign w_grant_if = w_idle & ifReq & ~w_grant_dm;
  assign memEn      = w_busy;
  assign err        = r_state == ERR;
  assign ifStall    = ifReq & ~ifValid;
  assign dmStall    = dmReq & ~dmValid;
  arb_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_grant_if | w_grant_dm),
    .enable (w_busy & ~memDone),
    .expired(w_expired)
  );
  always_comb begin
    w_next = r_state;
    if (w_grant_dm) w_next = BUSY_DM;
    else if (w_grant_if) w_next = BUSY_IF;
    else if (w_busy & memDone) w_next = IDLE;
    else if (w_expired) w_next = ERR;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_starve  <= '0;
      memWr     <= 1'b0;
      memAddr   <= '0;
      memWrData <= '0;
      ifValid   <= 1'b0;
      dmValid   <= 1'b0;
      ifData    <= '0;
      dmData    <= '0;
    end else begin
      r_state <= w_next;
      ifValid <= (r_state == BUSY_IF) & memDone;
      dmValid <= (r_state == BUSY_DM) & memDone;
      if ((r_state == BUSY_IF) && memDone) ifData <= memRdData;
      if ((r_state == BUSY_DM) && memDone && !memWr) dmData <= memRdData;
      if (w_grant_if) begin
        r_starve  <= '0;
        memAddr   <= ifAddr;
        memWrData <= '0;
        memWr     <= 1'b0;
      end
      if (w_grant_dm) begin
        memAddr   <= dmAddr;
        memWrData <= dmWrData;
        memWr     <= dmWr;
        if (ifReq && r_starve != 2'(STARVE_MAX)) r_starve <= r_starve + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 0, rst = 0;
  logic        ifReq = 0, dmReq = 0, dmWr = 0;
  logic [15:0] ifAddr = 0, dmAddr = 0, dmWrData = 0;
  logic        ifValid, ifStall, dmValid, dmStall, memEn, memWr, err;
  logic [15:0] ifData, dmData, memAddr, memWrData;
  logic [15:0] memRdData = 0;
  logic        memDone = 0;
  logic        hang = 0, force_done = 0;
  int          lat = 0, wcnt = 0;
  logic [15:0] key = 0;
  logic [15:0] if_q[$], dm_q[$];
  string       pn_q[$];
  logic [31:0] pa_q[$], pe_q[$];
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifValid(ifValid), .ifData(ifData), .ifStall(ifStall),
    .dmReq(dmReq), .dmWr(dmWr), .dmAddr(dmAddr), .dmWrData(dmWrData),
    .dmValid(dmValid), .dmData(dmData), .dmStall(dmStall),
    .memEn(memEn), .memWr(memWr), .memAddr(memAddr), .memWrData(memWrData),
    .memRdData(memRdData), .memDone(memDone), .err(err)
  );
  // memory model: answers lat cycles after memEn rises, data = address ^ key
  always @(negedge clk) begin
    memDone   = force_done | (memEn & ~hang & (wcnt == lat));
    memRdData = memAddr ^ key;
    wcnt      = memEn ? wcnt + 1 : 0;
  end
  task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (ifValid) begin
      if (if_q.size() == 0) cmp("ifValid_unexpected", {31'd0, ifValid}, 0);
      else cmp("ifData", {16'd0, ifData}, {16'd0, if_q.pop_front()});
    end
    if (dmValid) begin
      if (dm_q.size() == 0) cmp("dmValid_unexpected", {31'd0, dmValid}, 0);
      else cmp("dmData", {16'd0, dmData}, {16'd0, dm_q.pop_front()});
    end
    while (pn_q.size() > 0) cmp(pn_q.pop_front(), pa_q.pop_front(), pe_q.pop_front());
  end
  task automatic probe(string nm, logic [31:0] a, logic [31:0] e);
    pn_q.push_back(nm);
    pa_q.push_back(a);
    pe_q.push_back(e);
  endtask
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tick(2);
    probe("rst_memEn", memEn, 0);
    probe("rst_memWr", memWr, 0);
    probe("rst_memAddr", memAddr, 0);
    probe("rst_memWrData", memWrData, 0);
    probe("rst_valids", {ifValid, dmValid}, 0);
    probe("rst_data", {ifData, dmData}, 0);
    probe("rst_err", err, 0);
    rst = 1;
    tick;
    // fetch read, memDone one cycle after memEn
    key = 16'hBEAF; lat = 1; ifAddr = 16'h0040; ifReq = 1; if_q.push_back(16'hBEEF);
    tick;
    probe("if_memEn", memEn, 1);
    probe("if_memWr", memWr, 0);
    probe("if_memAddr", memAddr, 16'h0040);
    probe("if_stall_busy", ifStall, 1);
    tick;
    probe("if_memEn_hold", memEn, 1);
    probe("if_memWr_hold", memWr, 0);
    tick;
    probe("if_valid", ifValid, 1);
    probe("if_stall_valid", ifStall, 0);
    ifReq = 0;
    tick;
    probe("if_valid_one_cycle", ifValid, 0);
    probe("if_memEn_idle", memEn, 0);
    force_done = 1;
    tick(2);
    probe("idle_done_ignored", {memEn, ifValid, dmValid}, 0);
    force_done = 0;
    tick;
    // data read 0x5A5A
    key = 16'h7A5A; lat = 0; dmAddr = 16'h2000; dmWr = 0; dmReq = 1; dm_q.push_back(16'h5A5A);
    tick;
    probe("dr_stall", dmStall, 1);
    probe("dr_memAddr", memAddr, 16'h2000);
    tick;
    probe("dr_valid", dmValid, 1);
    probe("dr_stall_valid", dmStall, 0);
    dmReq = 0;
    tick;
    // data write: dmData must keep 0x5A5A although memory returns 0xEFFF
    key = 16'hFFFF; lat = 2; dmAddr = 16'h1000; dmWrData = 16'h1234; dmWr = 1; dmReq = 1;
    dm_q.push_back(16'h5A5A);
    tick;
    probe("dw_memWr", memWr, 1);
    probe("dw_memAddr", memAddr, 16'h1000);
    probe("dw_memWrData", memWrData, 16'h1234);
    tick;
    probe("dw_memWrData_hold", memWrData, 16'h1234);
    tick;
    probe("dw_hold_all", {memEn, memWr, memAddr}, {1'b1, 1'b1, 16'h1000});
    tick;
    probe("dw_valid", dmValid, 1);
    dmReq = 0; dmWr = 0;
    tick;
    // anti-starvation: three data grants, then fetch, then data again
    key = 16'hA5A5; lat = 0; ifAddr = 16'h0A00; dmAddr = 16'h0D00; ifReq = 1; dmReq = 1;
    repeat (3) dm_q.push_back(16'hA8A5);
    if_q.push_back(16'hAFA5);
    dm_q.push_back(16'hA8A5);
    for (int g = 0; g < 4; g++) begin
      tick;
      probe($sformatf("starve_grant%0d_addr", g), memAddr, (g == 3) ? 16'h0A00 : 16'h0D00);
      tick;
    end
    tick;
    probe("starve_cleared_addr", memAddr, 16'h0D00);
    ifReq = 0; dmReq = 0;
    tick;
    probe("drop_mid_access_valid", dmValid, 1);
    tick;
    // back-to-back fetch with request held through Valid
    key = 16'h1111; lat = 0; ifAddr = 16'h0300; ifReq = 1;
    if_q.push_back(16'h1211); if_q.push_back(16'h1211);
    tick;
    probe("b2b_busy", {memEn, ifStall}, 2'b11);
    tick;
    probe("b2b_valid", {ifValid, ifStall, memEn}, 3'b100);
    tick;
    probe("b2b_regrant", {memEn, ifStall}, 2'b11);
    ifReq = 0;
    tick(2);
    // reset mid-access
    hang = 1; ifAddr = 16'h0600; ifReq = 1;
    tick(2);
    probe("mid_busy", memEn, 1);
    rst = 0;
    #1;
    probe("async_rst_mem", {memEn, memWr, memAddr, memWrData}, 0);
    probe("async_rst_data", {ifData, dmData, ifValid, dmValid, err}, 0);
    hang = 0; lat = 1; ifAddr = 16'h0700; key = 16'hC7DE;
    tick(2);
    probe("held_rst_memEn", memEn, 0);
    rst = 1;
    if_q.push_back(16'hC0DE);
    tick;
    probe("post_rst_grant", {memEn, memAddr}, {1'b1, 16'h0700});
    tick(2);
    probe("post_rst_valid", ifValid, 1);
    ifReq = 0;
    tick;
    // timeout into ERR
    hang = 1; dmAddr = 16'h0F00; dmWr = 0; dmReq = 1;
    tick;
    tick(14);
    probe("to_last_busy", {memEn, err}, 2'b10);
    dmReq = 0;
    tick;
    probe("to_err", {memEn, err}, 2'b01);
    force_done = 1; ifReq = 1; dmReq = 1;
    tick(4);
    probe("err_sticky", {memEn, err, ifStall, dmStall}, 4'b0111);
    force_done = 0; ifReq = 0; dmReq = 0;
    rst = 0;
    #1;
    probe("err_cleared_by_rst", err, 0);
    hang = 0; lat = 0; key = 16'h0000;
    tick;
    rst = 1;
    tick;
    dmAddr = 16'h0ABC; dmReq = 1; dm_q.push_back(16'h0ABC);
    tick;
    probe("post_err_grant", {memEn, memAddr}, {1'b1, 16'h0ABC});
    tick;
    probe("post_err_valid", dmValid, 1);
    dmReq = 0;
    tick;
    probe("if_q_left", if_q.size(), 0);
    probe("dm_q_left", dm_q.size(), 0);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
